// File: rtl/io_bus_responder_pkg.sv
// io_bus_responder_pkg: I/O window address map shared by the responder and the CPU decode
package io_bus_responder_pkg;
    localparam logic [15:0] IO_BASE    = 16'hFFF0;
    localparam logic [15:0] IO_KEY     = 16'hFFF0;
    localparam logic [15:0] IO_SW      = 16'hFFF2;
    localparam logic [15:0] IO_PRESS   = 16'hFFF4;
    localparam logic [15:0] IO_HEX     = 16'hFFF8;
    localparam logic [15:0] IO_LEDR    = 16'hFFFA;
    localparam logic [15:0] IO_LEDG    = 16'hFFFC;
    localparam logic [15:0] IO_BADVAL  = 16'hDEAD;
endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchroniser per bit, followed by a prescaled debounce stage when IO_DEBOUNCE_EN is defined
module io_debounce #(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 500000,
    parameter int PBITS      = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] db
);
    logic [WIDTH-1:0] meta, sync;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
`ifdef IO_DEBOUNCE_EN
    logic [PBITS-1:0] cnt;
    logic [WIDTH-1:0] smp, same;
    logic             tick;
    assign tick = cnt == PBITS'(DEB_CYCLES - 1);
    assign same = ~(sync ^ smp);
    // a bit only follows the input once two consecutive tick samples agree
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            smp <= '0;
            db  <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                smp <= sync;
                db  <= (db & ~same) | (sync & same);
            end
        end
`else
    logic [PBITS-1:0] unused_cfg;
    assign unused_cfg = PBITS'(DEB_CYCLES);
    assign db = sync;
`endif
endmodule

// File: rtl/io_bus_responder.sv
// io_bus_responder: memory-mapped I/O at 0xFFF0-0xFFFF (HEX/LEDR/LEDG stores, KEY/SW loads, sticky presses).
// Define IO_DEBOUNCE_EN to debounce KEY/SW; otherwise they are only synchronised.
module io_bus_responder
    import io_bus_responder_pkg::*;
#(
    parameter int DBITS      = 16,
    parameter int DEB_CYCLES = 500000,
    parameter int PBITS      = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DBITS-1:0] addr,
    input  logic             we,
    input  logic             re,
    input  logic [DBITS-1:0] din,
    output logic [DBITS-1:0] dout,
    output logic             sel,
    input  logic [3:0]       key,
    input  logic [9:0]       sw,
    output logic [15:0]      hex,
    output logic [9:0]       ledr,
    output logic [7:0]       ledg
);
    logic [3:0] key_db, key_prev, press, ovr, rise, clr_press, clr_ovr;
    logic [9:0] sw_db;
    logic       wr, w1c;
    logic       unused_re;

    io_debounce #(.WIDTH(4), .DEB_CYCLES(DEB_CYCLES), .PBITS(PBITS)) u_key (
        .clk(clk), .rst_n(rst_n), .raw(~key), .db(key_db)
    );
    io_debounce #(.WIDTH(10), .DEB_CYCLES(DEB_CYCLES), .PBITS(PBITS)) u_sw (
        .clk(clk), .rst_n(rst_n), .raw(sw), .db(sw_db)
    );

    assign sel       = addr[15:4] == IO_BASE[15:4];
    assign wr        = we && sel;
    assign w1c       = wr && addr == IO_PRESS;
    assign rise      = key_db & ~key_prev;
    assign clr_press = w1c ? din[3:0] : 4'h0;
    assign clr_ovr   = w1c ? din[7:4] : 4'h0;
    assign unused_re = re;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hex      <= '0;
            ledr     <= '0;
            ledg     <= '0;
            key_prev <= '0;
            press    <= '0;
            ovr      <= '0;
        end else begin
            key_prev <= key_db;
            // a fresh press beats a same-cycle clear of the same bit
            press    <= (press & ~clr_press) | rise;
            ovr      <= (ovr & ~clr_ovr) | (press & rise);
            if (wr && addr == IO_HEX) hex <= din[15:0];
            if (wr && addr == IO_LEDR) ledr <= din[9:0];
            if (wr && addr == IO_LEDG) ledg <= din[7:0];
        end

    always_comb
        dout = addr == IO_KEY   ? {12'h0, key_db} :
               addr == IO_SW    ? {6'h0, sw_db} :
               addr == IO_PRESS ? {8'h0, ovr, press} :
               addr == IO_HEX   ? hex :
               addr == IO_LEDR  ? {6'h0, ledr} :
               addr == IO_LEDG  ? {8'h0, ledg} : IO_BADVAL;
endmodule
